// File: rtl/generic_mux_pkg.sv
// Shared types and helpers for the generic stream multiplexer family.
package generic_mux_pkg;

  typedef enum logic {
    MuxSel = 1'b0,
    MuxRr  = 1'b1
  } mux_mode_e;

  // Index width; a single-input mux still carries a 1-bit index.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/generic_mux.sv
// Combinational N:1 data multiplexer; out-of-range select yields zero.
module generic_mux
  import generic_mux_pkg::*;
#(
  parameter  int unsigned WIDTH   = 1,
  parameter  int unsigned NUMBER  = 2,
  localparam int unsigned SelectW = sel_width(NUMBER)
) (
  input  logic [SelectW-1:0] sel,
  input  logic [WIDTH-1:0]   in_data [NUMBER],
  output logic [WIDTH-1:0]   out_data
);

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < NUMBER; i++) begin
      if (sel == SelectW'(i)) out_data = in_data[i];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
  import generic_mux_pkg::*;
#(
  parameter  int unsigned NUMBER  = 2,
  localparam int unsigned SelectW = sel_width(NUMBER)
) (
  input  logic [NUMBER-1:0]  req,
  input  logic [SelectW-1:0] ptr,
  output logic [NUMBER-1:0]  grant,
  output logic [SelectW-1:0] idx,
  output logic               valid
);

  logic               hi_found;
  logic [SelectW-1:0] hi_idx;
  logic [SelectW-1:0] lo_idx;

  // Wrap search split into two priority scans: indices >= ptr first, then the rest.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = NUMBER; i > 0; i--) begin
      if (req[i-1]) begin
        lo_idx = SelectW'(i - 1);
        if (SelectW'(i - 1) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = SelectW'(i - 1);
        end
      end
    end
  end

  assign valid = |req;
  assign idx   = hi_found ? hi_idx : lo_idx;

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUMBER; i++) begin
      grant[i] = valid && (idx == SelectW'(i));
    end
  end

endmodule

// File: rtl/generic_stream_mux.sv
// Registered N:1 stream mux with explicit-select or round-robin arbitration.
module generic_stream_mux
  import generic_mux_pkg::*;
#(
  parameter  int unsigned WIDTH   = 1,
  parameter  int unsigned NUMBER  = 2,
  localparam int unsigned SelectW = sel_width(NUMBER)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  mux_mode_e          mode_i,
  input  logic [SelectW-1:0] sel_i,
  input  logic [WIDTH-1:0]   in_data_i [NUMBER],
  input  logic [NUMBER-1:0]  in_valid_i,
  output logic [NUMBER-1:0]  in_ready_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SelectW-1:0] out_idx_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  logic               load;
  logic               transfer;
  logic               gnt_any;
  logic [SelectW-1:0] gnt_idx;
  logic [NUMBER-1:0]  gnt_vec;
  logic [NUMBER-1:0]  sel_vec;
  logic [SelectW-1:0] sel_idx;
  logic [NUMBER-1:0]  rr_grant;
  logic [SelectW-1:0] rr_idx;
  logic               rr_any;
  logic [SelectW-1:0] rr_ptr;
  logic [WIDTH-1:0]   mux_data;

  // Holding reset in load keeps every input unacknowledged while rst_ni is low.
  assign load = rst_ni && (!out_valid_o || out_ready_i);

  // Out-of-range sel_i matches no index, so it can never produce a grant.
  always_comb begin
    sel_vec = '0;
    for (int unsigned i = 0; i < NUMBER; i++) begin
      sel_vec[i] = in_valid_i[i] && (sel_i == SelectW'(i));
    end
  end

  assign sel_idx = sel_i;

  rr_arbiter #(
    .NUMBER (NUMBER)
  ) u_arb (
    .req   (in_valid_i),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .valid (rr_any)
  );

  always_comb begin
    if (mode_i == MuxRr) begin
      gnt_vec = rr_grant;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else begin
      gnt_vec = sel_vec;
      gnt_idx = sel_idx;
      gnt_any = |sel_vec;
    end
  end

  assign in_ready_o = gnt_vec & {NUMBER{load}};
  assign transfer   = gnt_any && load;

  generic_mux #(
    .WIDTH  (WIDTH),
    .NUMBER (NUMBER)
  ) u_mux (
    .sel      (gnt_idx),
    .in_data  (in_data_i),
    .out_data (mux_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_idx_o   <= '0;
      rr_ptr      <= '0;
    end else begin
      if (load) begin
        if (gnt_any) begin
          out_data_o  <= mux_data;
          out_idx_o   <= gnt_idx;
          out_valid_o <= 1'b1;
        end else begin
          out_valid_o <= 1'b0;
        end
      end
      if (transfer && (mode_i == MuxRr)) begin
        rr_ptr <= (gnt_idx == SelectW'(NUMBER - 1)) ? '0 : gnt_idx + SelectW'(1);
      end
    end
  end

endmodule

// File: tb/tb_generic_stream_mux.sv
// Scoreboard bench for generic_stream_mux (NUMBER=4 main instance, NUMBER=5 edge instance).
module tb_generic_stream_mux;
  import generic_mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  mux_mode_e  mode;
  logic [1:0] sel;
  logic [7:0] in_data [4];
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  logic       out_valid;
  logic       out_ready;

  mux_mode_e  mode5;
  logic [2:0] sel5;
  logic [7:0] data5 [5];
  logic [4:0] valid5;
  logic [4:0] rdy5;
  logic [7:0] od5;
  logic [2:0] oidx5;
  logic       ov5;
  logic       or5;

  generic_stream_mux #(.WIDTH(8), .NUMBER(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .sel_i(sel),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_idx_o(out_idx), .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  generic_stream_mux #(.WIDTH(8), .NUMBER(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode5), .sel_i(sel5),
    .in_data_i(data5), .in_valid_i(valid5), .in_ready_o(rdy5),
    .out_data_o(od5), .out_idx_o(oidx5), .out_valid_o(ov5),
    .out_ready_i(or5)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] sbq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Consumes a beat whenever the output handshake completes at the coming edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [9:0] e;
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: actual idx=%0d data=%0h required=no beat", out_idx, out_data);
      end else begin
        e = sbq.pop_front();
        check("beat_data", {24'd0, out_data}, {24'd0, e[7:0]});
        check("beat_idx", {30'd0, out_idx}, {30'd0, e[9:8]});
      end
    end
  end

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < 4; i++) in_data[i] = base + 8'(i);
  endtask

  task automatic step(input string name, input logic [3:0] exp_rdy, input bit push,
                      input logic [1:0] idx, input logic [7:0] d);
    @(negedge clk);
    check(name, {28'd0, in_ready}, {28'd0, exp_rdy});
    if (push) sbq.push_back({idx, d});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = MuxSel;
    sel       = 2'd0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    set_data(8'h10);
    mode5  = MuxSel;
    sel5   = 3'd5;
    valid5 = '1;
    or5    = 1'b1;
    for (int i = 0; i < 5; i++) data5[i] = 8'h40 + 8'(i);

    // Reset with every input valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_ready", {28'd0, in_ready}, 32'd0);
    check("reset_data", {24'd0, out_data}, 32'd0);
    check("reset_idx", {30'd0, out_idx}, 32'd0);
    check("reset_ready5", {27'd0, rdy5}, 32'd0);
    in_valid = 4'h0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Explicit select
    mode = MuxSel;
    sel = 2'd2;
    in_valid = 4'hF;
    in_data[2] = 8'hA5;
    step("t2_ready0", 4'b0100, 1, 2'd2, 8'hA5);
    in_data[2] = 8'h5A;
    step("t2_ready1", 4'b0100, 1, 2'd2, 8'h5A);
    in_valid = 4'h0;
    step("t2_idle", 4'b0000, 0, 2'd0, 8'h00);
    in_valid = 4'b1101;
    sel = 2'd1;
    step("t2_sel_invalid", 4'b0000, 0, 2'd0, 8'h00);
    check("t2_bubble_valid", {31'd0, out_valid}, 32'd0);

    // Round-robin, all valid: 0,1,2,3,0,1 back-to-back
    mode = MuxRr;
    in_valid = 4'hF;
    set_data(8'h20);
    for (int i = 0; i < 6; i++)
      step("t3_ready", 4'(1 << (i % 4)), 1, 2'(i % 4), 8'h20 + 8'(i % 4));

    // Backpressure holds the idx1 beat; ptr is now 2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("t4_ready", 4'b0000, 0, 2'd0, 8'h00);
      check("t4_valid", {31'd0, out_valid}, 32'd1);
      check("t4_data", {24'd0, out_data}, 32'h21);
      check("t4_idx", {30'd0, out_idx}, 32'd1);
    end
    out_ready = 1'b1;
    step("t4_resume", 4'b0100, 1, 2'd2, 8'h22);

    // Sparse round-robin from ptr=3
    in_valid = 4'b0010;
    in_data[1] = 8'h61;
    step("t5_one", 4'b0010, 1, 2'd1, 8'h61);
    in_valid = 4'b1010;
    in_data[3] = 8'h63;
    step("t5_first", 4'b1000, 1, 2'd3, 8'h63);
    step("t5_second", 4'b0010, 1, 2'd1, 8'h61);

    // Out-of-range select on the 5-input instance
    in_valid = 4'h0;
    @(negedge clk);
    check("t6_sel5_ready", {27'd0, rdy5}, 32'd0);
    check("t6_sel5_valid", {31'd0, ov5}, 32'd0);
    sel5 = 3'd4;
    #1;
    check("t6_sel4_ready", {27'd0, rdy5}, 32'b10000);
    @(posedge clk);
    #1;
    check("t6_sel4_valid", {31'd0, ov5}, 32'd1);
    check("t6_sel4_data", {24'd0, od5}, 32'h44);
    check("t6_sel4_idx", {29'd0, oidx5}, 32'd4);

    // Async reset during backpressure discards the held beat and clears ptr
    in_valid = 4'hF;
    set_data(8'h20);
    step("t6_pre", 4'b0100, 1, 2'd2, 8'h22);
    out_ready = 1'b0;
    step("t6_bp", 4'b0000, 0, 2'd0, 8'h00);
    check("t6_queue_held", sbq.size(), 32'd1);
    sbq.delete();
    #2;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_data", {24'd0, out_data}, 32'd0);
    check("t6_rst_idx", {30'd0, out_idx}, 32'd0);
    check("t6_rst_ready", {28'd0, in_ready}, 32'd0);
    check("t6_rst_valid5", {31'd0, ov5}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_ptr0_ready", {28'd0, in_ready}, 32'b0001);
    sbq.push_back({2'd0, 8'h20});
    @(posedge clk);
    #1;
    step("t6_ptr1_ready", 4'b0010, 1, 2'd1, 8'h21);

    in_valid = 4'h0;
    step("drain", 4'b0000, 0, 2'd0, 8'h00);
    step("drain", 4'b0000, 0, 2'd0, 8'h00);
    check("queue_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
